// File: rtl/cache_refill_ctrl_pkg.sv
// Shared definitions for the cache line-refill engine: FSM encoding and
// backend address width helper.
package cache_refill_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_COMMIT = 2'd2
    } state_e;

    // Byte address = tag | set index | word in line | byte in word.
    function automatic int unsigned be_addr_w(input int unsigned tag_w,
                                              input int unsigned line_off_w,
                                              input int unsigned word_off_w,
                                              input int unsigned data_w);
        return tag_w + line_off_w + word_off_w + $clog2(data_w / 8);
    endfunction

endpackage

// File: rtl/cache_refill_ctrl_bin_to_onehot.sv
// Binary way index to one-hot way vector; inverse of onehot_to_bin.
module bin_to_onehot #(
    parameter  int unsigned N = 8,
    localparam int unsigned W = $clog2(N)
) (
    input  logic [W-1:0] bin,
    output logic [N-1:0] onehot
);

    always_comb onehot = N'(1) << bin;

endmodule

// File: rtl/cache_refill_ctrl.sv
// Line-refill engine: fetches one cache line from backend memory into the victim
// way, then writes tag/valid and marks the way MRU. Optional critical-word-first
// ordering and early_valid output under CACHE_REFILL_CRITICAL_FIRST_EN.
module cache_refill_ctrl
    import cache_refill_ctrl_pkg::*;
#(
    parameter  int unsigned N_WAYS     = 8,
    parameter  int unsigned LINE_OFF_W = 4,
    parameter  int unsigned WORD_OFF_W = 2,
    parameter  int unsigned BE_DATA_W  = 32,
    parameter  int unsigned TAG_W      = 24,
    localparam int unsigned NWAY_W     = $clog2(N_WAYS),
    localparam int unsigned BE_ADDR_W  = be_addr_w(TAG_W, LINE_OFF_W, WORD_OFF_W, BE_DATA_W)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  miss_req,
    input  logic [TAG_W-1:0]      miss_tag,
    input  logic [LINE_OFF_W-1:0] miss_index,
    input  logic [WORD_OFF_W-1:0] miss_word,
    input  logic [NWAY_W-1:0]     way_select_bin,
    output logic                  refill_busy,
    output logic                  refill_done,
    output logic                  mem_valid,
    output logic [BE_ADDR_W-1:0]  mem_addr,
    input  logic                  mem_ready,
    input  logic [BE_DATA_W-1:0]  mem_rdata,
    output logic [N_WAYS-1:0]     line_wr_en,
    output logic [LINE_OFF_W-1:0] line_wr_index,
    output logic [WORD_OFF_W-1:0] line_wr_word,
    output logic [BE_DATA_W-1:0]  line_wr_data,
    output logic [N_WAYS-1:0]     tag_wr_en,
    output logic [TAG_W-1:0]      tag_wr_data,
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    output logic                  early_valid,
`endif
    output logic                  pol_write_en,
    output logic [N_WAYS-1:0]     pol_way_hit,
    output logic [LINE_OFF_W-1:0] pol_line_addr
);

    localparam int unsigned BYTE_OFF_W = $clog2(BE_DATA_W / 8);
    localparam logic [WORD_OFF_W-1:0] LAST_WORD = '1;

    state_e                  state_q, state_d;
    logic [TAG_W-1:0]        tag_q, tag_d;
    logic [LINE_OFF_W-1:0]   index_q, index_d;
    logic [NWAY_W-1:0]       way_q, way_d;
    logic [WORD_OFF_W-1:0]   word_cnt_q, word_cnt_d;
    logic [WORD_OFF_W-1:0]   done_cnt_q, done_cnt_d;
    logic [N_WAYS-1:0]       way_oh;
    logic [WORD_OFF_W-1:0]   start_word;

`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
    assign start_word = miss_word;
`else
    logic unused_miss_word;
    assign start_word       = '0;
    assign unused_miss_word = ^miss_word;
`endif

    bin_to_onehot #(.N(N_WAYS)) u_way_oh (
        .bin    (way_q),
        .onehot (way_oh)
    );

    // Next state and outputs; data-memory writes follow mem_ready in the same cycle.
    always_comb begin
        state_d       = state_q;
        tag_d         = tag_q;
        index_d       = index_q;
        way_d         = way_q;
        word_cnt_d    = word_cnt_q;
        done_cnt_d    = done_cnt_q;
        refill_busy   = 1'b0;
        refill_done   = 1'b0;
        mem_valid     = 1'b0;
        mem_addr      = '0;
        line_wr_en    = '0;
        line_wr_index = '0;
        line_wr_word  = '0;
        line_wr_data  = '0;
        tag_wr_en     = '0;
        tag_wr_data   = '0;
        pol_write_en  = 1'b0;
        pol_way_hit   = '0;
        pol_line_addr = '0;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
        early_valid   = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (miss_req) begin
                    tag_d      = miss_tag;
                    index_d    = miss_index;
                    way_d      = way_select_bin;
                    word_cnt_d = start_word;
                    done_cnt_d = '0;
                    state_d    = ST_FILL;
                end
            end
            ST_FILL: begin
                refill_busy = 1'b1;
                mem_valid   = 1'b1;
                mem_addr    = {tag_q, index_q, word_cnt_q, {BYTE_OFF_W{1'b0}}};
                if (mem_ready) begin
                    line_wr_en    = way_oh;
                    line_wr_index = index_q;
                    line_wr_word  = word_cnt_q;
                    line_wr_data  = mem_rdata;
`ifdef CACHE_REFILL_CRITICAL_FIRST_EN
                    early_valid   = (done_cnt_q == '0);
`endif
                    word_cnt_d    = word_cnt_q + WORD_OFF_W'(1);
                    done_cnt_d    = done_cnt_q + WORD_OFF_W'(1);
                    if (done_cnt_q == LAST_WORD) begin
                        state_d = ST_COMMIT;
                    end
                end
            end
            ST_COMMIT: begin
                refill_busy   = 1'b1;
                refill_done   = 1'b1;
                tag_wr_en     = way_oh;
                tag_wr_data   = tag_q;
                pol_write_en  = 1'b1;
                pol_way_hit   = way_oh;
                pol_line_addr = index_q;
                state_d       = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            tag_q      <= '0;
            index_q    <= '0;
            way_q      <= '0;
            word_cnt_q <= '0;
            done_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            tag_q      <= tag_d;
            index_q    <= index_d;
            way_q      <= way_d;
            word_cnt_q <= word_cnt_d;
            done_cnt_q <= done_cnt_d;
        end
    end

endmodule
